// File: rtl/alu_logic_pkg.sv
// rtl/alu_logic_pkg.sv - opcodes, flag indices and shift modes shared by alu_logic_pipe
// Purpose: common definitions for the pipelined logic/shift unit.
// Ports: none (package).
package alu_logic_pkg;

  localparam logic [3:0] OP_AND    = 4'd0;
  localparam logic [3:0] OP_OR     = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_NOT    = 4'd3;
  localparam logic [3:0] OP_NAND   = 4'd4;
  localparam logic [3:0] OP_NOR    = 4'd5;
  localparam logic [3:0] OP_SHL    = 4'd6;
  localparam logic [3:0] OP_SHR    = 4'd7;
  localparam logic [3:0] OP_SAR    = 4'd8;
  localparam logic [3:0] OP_ROL    = 4'd9;
  localparam logic [3:0] OP_ROR    = 4'd10;
  localparam logic [3:0] OP_XNOR   = 4'd11;
  localparam logic [3:0] OP_BSET   = 4'd12;
  localparam logic [3:0] OP_BCLR   = 4'd13;
  localparam logic [3:0] OP_BTGL   = 4'd14;
  localparam logic [3:0] OP_POPCNT = 4'd15;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_PAR   = 4;

  typedef enum logic [2:0] {
    SH_NONE,
    SH_SHL,
    SH_SHR,
    SH_SAR,
    SH_ROL,
    SH_ROR
  } shift_mode_t;

  // Non-shift opcodes map to SH_NONE so the shift slices pass data through.
  function automatic shift_mode_t op_to_mode(input logic [3:0] op);
    case (op)
      OP_SHL:  return SH_SHL;
      OP_SHR:  return SH_SHR;
      OP_SAR:  return SH_SAR;
      OP_ROL:  return SH_ROL;
      OP_ROR:  return SH_ROR;
      default: return SH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_stage.sv
// rtl/alu_shift_stage.sv - barrel-shift slice covering shift levels LEVEL_LO..LEVEL_HI
// Purpose: applies the shift-amount bits of one pipeline stage.
// Ports: mode (shift kind), sh (amount bits LEVEL_HI..LEVEL_LO), data_in, data_out.
module alu_shift_stage
  import alu_logic_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LEVEL_LO = 0,
  parameter int LEVEL_HI = 0
) (
  input  shift_mode_t                  mode,
  input  logic [LEVEL_HI-LEVEL_LO:0]   sh,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             data_out
);

  // Each set amount bit k shifts by 2**(k+LEVEL_LO); slices compose across stages.
  always_comb begin
    data_out = data_in;
    for (int k = 0; k <= LEVEL_HI - LEVEL_LO; k++) begin
      if (sh[k]) begin
        case (mode)
          SH_SHL: data_out = data_out << (1 << (k + LEVEL_LO));
          SH_SHR: data_out = data_out >> (1 << (k + LEVEL_LO));
          SH_SAR: data_out = $signed(data_out) >>> (1 << (k + LEVEL_LO));
          SH_ROL: data_out = (data_out << (1 << (k + LEVEL_LO)))
                           | (data_out >> (WIDTH - (1 << (k + LEVEL_LO))));
          SH_ROR: data_out = (data_out >> (1 << (k + LEVEL_LO)))
                           | (data_out << (WIDTH - (1 << (k + LEVEL_LO))));
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_logic_pipe.sv
// rtl/alu_logic_pipe.sv - two-stage pipelined logic/shift unit with valid/ready handshake
// Purpose: one op per cycle, fixed 2-cycle latency, result + flags + tag.
// Ports: clk, rst (sync active-high); in_valid/in_ready/in_op/in_a/in_b/in_tag;
//        out_valid/out_ready/out_result/out_flags {par,ovf,carry,neg,zero}/out_tag.
module alu_logic_pipe
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHW     = $clog2(WIDTH);
  localparam int LO_BITS = SHW / 2;  // amount bits resolved in stage 2

  logic               s1_valid;
  logic [3:0]         s1_op;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_res;
  logic [LO_BITS-1:0] s1_sh_lo;
  logic [TAG_W-1:0]   s1_tag;
  logic               s1_carry;
  logic               s2_valid;
  logic               s1_adv;
  logic               s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // ---------------- stage 1 ----------------
  logic [SHW-1:0]   sh;
  logic [SHW-1:0]   left_idx;
  logic [SHW-1:0]   right_idx;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] shift_hi;
  logic [WIDTH-1:0] res1;
  logic             carry1;

  assign sh        = in_b[SHW-1:0];
  assign left_idx  = SHW'(0) - sh;    // WIDTH-sh modulo WIDTH
  assign right_idx = sh - SHW'(1);
  assign mask      = {{(WIDTH-1){1'b0}}, 1'b1} << sh;

  alu_shift_stage #(
    .WIDTH(WIDTH), .LEVEL_LO(LO_BITS), .LEVEL_HI(SHW-1)
  ) u_shift_hi (
    .mode(op_to_mode(in_op)),
    .sh(sh[SHW-1:LO_BITS]),
    .data_in(in_a),
    .data_out(shift_hi)
  );

  always_comb begin
    res1 = shift_hi;  // shifts carry the partial shift; POPCNT is finished in stage 2
    case (in_op)
      OP_AND:  res1 = in_a & in_b;
      OP_OR:   res1 = in_a | in_b;
      OP_XOR:  res1 = in_a ^ in_b;
      OP_NOT:  res1 = ~in_a;
      OP_NAND: res1 = ~(in_a & in_b);
      OP_NOR:  res1 = ~(in_a | in_b);
      OP_XNOR: res1 = ~(in_a ^ in_b);
      OP_BSET: res1 = in_a | mask;
      OP_BCLR: res1 = in_a & ~mask;
      OP_BTGL: res1 = in_a ^ mask;
      default: ;
    endcase
  end

  // Carry is the last bit shifted out, taken from the unshifted operand.
  always_comb begin
    carry1 = 1'b0;
    if (sh != '0) begin
      case (in_op)
        OP_SHL, OP_ROL:         carry1 = in_a[left_idx];
        OP_SHR, OP_SAR, OP_ROR: carry1 = in_a[right_idx];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_op    <= in_op;
      s1_a     <= in_a;
      s1_res   <= res1;
      s1_sh_lo <= sh[LO_BITS-1:0];
      s1_tag   <= in_tag;
      s1_carry <= carry1;
    end
  end

  // ---------------- stage 2 ----------------
  logic [WIDTH-1:0] shift_lo;
  logic [WIDTH-1:0] pop;
  logic [WIDTH-1:0] res2;
  logic [4:0]       flags2;

  alu_shift_stage #(
    .WIDTH(WIDTH), .LEVEL_LO(0), .LEVEL_HI(LO_BITS-1)
  ) u_shift_lo (
    .mode(op_to_mode(s1_op)),
    .sh(s1_sh_lo),
    .data_in(s1_res),
    .data_out(shift_lo)
  );

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + {{(WIDTH-1){1'b0}}, s1_a[i]};
    end
  end

  assign res2 = (s1_op == OP_POPCNT) ? pop : shift_lo;

  always_comb begin
    flags2            = '0;
    flags2[FLG_ZERO]  = (res2 == '0);
    flags2[FLG_NEG]   = res2[WIDTH-1];
    flags2[FLG_CARRY] = s1_carry;
    flags2[FLG_OVF]   = 1'b0;
    flags2[FLG_PAR]   = ^res2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_tag    <= '0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= res2;
          out_flags  <= flags2;
          out_tag    <= s1_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_logic_pipe.sv
// tb/tb_alu_logic_pipe.sv - self-checking bench for alu_logic_pipe
module tb_alu_logic_pipe;
  import alu_logic_pkg::*;

  localparam int N_RAND = 10000;

  logic clk;
  logic rst;
  logic go_rand;
  int   n_chk;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: whole-operation arithmetic on a w-bit value held in 64 bits.
  function automatic void ref_op(input int w, input logic [3:0] op,
                                 input logic [63:0] a_in, input logic [63:0] b_in,
                                 output logic [63:0] r, output logic [4:0] f);
    logic [63:0] m;
    logic [63:0] a;
    logic [63:0] b;
    int          sh;
    logic        c;
    m  = wmask(w);
    a  = a_in & m;
    b  = b_in & m;
    sh = int'(b & 64'(w - 1));
    c  = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a ^ b;
      4'd3:  r = ~a;
      4'd4:  r = ~(a & b);
      4'd5:  r = ~(a | b);
      4'd6:  begin r = a << sh; if (sh != 0) c = a[w-sh]; end
      4'd7:  begin r = a >> sh; if (sh != 0) c = a[sh-1]; end
      4'd8:  begin
               r = a >> sh;
               if (a[w-1]) r = r | (m & ~(m >> sh));
               if (sh != 0) c = a[sh-1];
             end
      4'd9:  begin
               r = a;
               if (sh != 0) begin r = (a << sh) | (a >> (w - sh)); c = a[w-sh]; end
             end
      4'd10: begin
               r = a;
               if (sh != 0) begin r = (a >> sh) | (a << (w - sh)); c = a[sh-1]; end
             end
      4'd11: r = ~(a ^ b);
      4'd12: r = a | (64'd1 << sh);
      4'd13: r = a & ~(64'd1 << sh);
      4'd14: r = a ^ (64'd1 << sh);
      default: r = 64'($countones(a));
    endcase
    r = r & m;
    f = {^r, 1'b0, c, r[w-1], (r == 64'd0)};
  endfunction

  // ---------------- WIDTH=32 instance for directed tests ----------------
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_op, in_tag, out_tag;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  out_flags;

  alu_logic_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flags;  // {par, ovf, carry, neg, zero}
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  // ---------------- random harnesses, WIDTH=8 and WIDTH=64 ----------------
  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int W = (g == 0) ? 8 : 64;
    logic         r_in_valid, r_in_ready, r_out_valid, r_out_ready;
    logic [3:0]   r_op, r_tag, r_otag;
    logic [W-1:0] r_a, r_b, r_res;
    logic [4:0]   r_flags;
    logic         done_flag;
    exp_t         q[$];

    alu_logic_pipe #(.WIDTH(W), .TAG_W(4)) dut_r (
      .clk(clk), .rst(rst),
      .in_valid(r_in_valid), .in_ready(r_in_ready), .in_op(r_op),
      .in_a(r_a), .in_b(r_b), .in_tag(r_tag),
      .out_valid(r_out_valid), .out_ready(r_out_ready),
      .out_result(r_res), .out_flags(r_flags), .out_tag(r_otag)
    );

    initial begin
      int           sent;
      int           cycles;
      logic         held;
      logic [W-1:0] h_res;
      logic [4:0]   h_flags;
      logic [3:0]   h_tag;
      logic [63:0]  er;
      logic [4:0]   ef;
      exp_t         e;
      done_flag   = 1'b0;
      r_in_valid  = 1'b0;
      r_out_ready = 1'b0;
      r_op = '0; r_a = '0; r_b = '0; r_tag = '0;
      sent = 0; cycles = 0; held = 1'b0;
      h_res = '0; h_flags = '0; h_tag = '0;
      wait (go_rand);
      while ((sent < N_RAND || q.size() != 0) && cycles < 60000) begin
        @(negedge clk);
        cycles++;
        r_in_valid  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
        r_op        = 4'($urandom_range(0, 15));
        r_a         = W'({$urandom, $urandom});
        r_b         = W'({$urandom, $urandom});
        r_tag       = 4'(sent);
        r_out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (held) begin
          chk($sformatf("w%0d_hold_valid", W), 64'(r_out_valid), 64'd1);
          chk($sformatf("w%0d_hold_res", W), 64'(r_res), 64'(h_res));
          chk($sformatf("w%0d_hold_flags", W), 64'(r_flags), 64'(h_flags));
          chk($sformatf("w%0d_hold_tag", W), 64'(r_otag), 64'(h_tag));
        end
        if (r_in_valid && r_in_ready) begin
          ref_op(W, r_op, 64'(r_a), 64'(r_b), er, ef);
          e.res = er; e.flags = ef; e.tag = r_tag;
          q.push_back(e);
          sent++;
        end
        if (r_out_valid && r_out_ready) begin
          if (q.size() == 0) begin
            chk($sformatf("w%0d_spurious_out", W), 64'(r_otag), 64'hDEAD);
          end else begin
            e = q.pop_front();
            chk($sformatf("w%0d_res", W), 64'(r_res), e.res);
            chk($sformatf("w%0d_flags", W), 64'(r_flags), 64'(e.flags));
            chk($sformatf("w%0d_tag", W), 64'(r_otag), 64'(e.tag));
          end
        end
        held    = r_out_valid && !r_out_ready;
        h_res   = r_res;
        h_flags = r_flags;
        h_tag   = r_otag;
      end
      chk($sformatf("w%0d_sent", W), 64'(sent), 64'(N_RAND));
      chk($sformatf("w%0d_drained", W), 64'(q.size()), 64'd0);
      @(negedge clk);
      r_in_valid = 1'b0;
      done_flag  = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(1500000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    vec_t        vecs[16];
    int          seen_tag[$];
    int          seen_cyc[$];
    logic [31:0] s_res;
    logic [4:0]  s_flags;
    n_chk = 0; n_fail = 0;
    go_rand  = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0;

    vecs[0]  = '{OP_SHL,    32'h80000001, 32'd1,        32'h00000002, 5'b10100};
    vecs[1]  = '{OP_ROR,    32'h00000001, 32'd4,        32'h10000000, 5'b10000};
    vecs[2]  = '{OP_ROR,    32'h00000001, 32'd1,        32'h80000000, 5'b10110};
    vecs[3]  = '{OP_SAR,    32'h80000000, 32'd31,       32'hFFFFFFFF, 5'b00010};
    vecs[4]  = '{OP_SHL,    32'h12345678, 32'h20,       32'h12345678, 5'b10000};
    vecs[5]  = '{OP_POPCNT, 32'hF0F0F0F0, 32'd0,        32'h00000010, 5'b10000};
    vecs[6]  = '{OP_BCLR,   32'hFFFFFFFF, 32'd31,       32'h7FFFFFFF, 5'b10000};
    vecs[7]  = '{OP_NOT,    32'hFFFFFFFF, 32'd0,        32'h00000000, 5'b00001};
    vecs[8]  = '{OP_ROL,    32'h80000000, 32'd1,        32'h00000001, 5'b10100};
    vecs[9]  = '{OP_SHR,    32'h00000003, 32'd1,        32'h00000001, 5'b10100};
    vecs[10] = '{OP_XOR,    32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 5'b00010};
    vecs[11] = '{OP_BSET,   32'h00000000, 32'h25,       32'h00000020, 5'b10000};
    vecs[12] = '{OP_NAND,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'b00001};
    vecs[13] = '{OP_SAR,    32'h40000000, 32'd30,       32'h00000001, 5'b10000};
    vecs[14] = '{OP_ROL,    32'h12345678, 32'd12,       32'h45678123, 5'b10100};
    vecs[15] = '{OP_BTGL,   32'h00000001, 32'd0,        32'h00000000, 5'b00001};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_flags", 64'(out_flags), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);

    // single ops: latency and values
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
      in_tag = 4'(i); out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_early_valid", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_res", i), 64'(out_result), 64'(vecs[i].res));
      chk($sformatf("v%0d_flags", i), 64'(out_flags), 64'(vecs[i].flags));
      chk($sformatf("v%0d_tag", i), 64'(out_tag), 64'(i));
    end

    // back-to-back tags 1,2,3 with out_ready low for 4 cycles
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = OP_OR; in_a = 32'd1; in_b = '0; in_tag = 4'd1;
    #1; chk("stall_acc1", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_a = 32'd2; in_tag = 4'd2;
    #1; chk("stall_acc2", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_a = 32'd3; in_tag = 4'd3;
    #1;
    chk("stall_full", 64'(in_ready), 64'd0);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_tag", 64'(out_tag), 64'd1);
    s_res = out_result; s_flags = out_flags;
    @(negedge clk);
    #1;
    chk("stall_full2", 64'(in_ready), 64'd0);
    chk("stall_hold_res", 64'(out_result), 64'(s_res));
    chk("stall_hold_flags", 64'(out_flags), 64'(s_flags));
    chk("stall_hold_tag", 64'(out_tag), 64'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        seen_tag.push_back(int'(out_tag));
        seen_cyc.push_back(k);
        chk($sformatf("drain_res_k%0d", k), 64'(out_result), 64'(out_tag));
      end
      if (in_valid && in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    chk("drain_count", 64'(seen_tag.size()), 64'd3);
    if (seen_tag.size() == 3) begin
      chk("drain_t0", 64'(seen_tag[0]), 64'd1);
      chk("drain_t1", 64'(seen_tag[1]), 64'd2);
      chk("drain_t2", 64'(seen_tag[2]), 64'd3);
      chk("drain_consecutive", 64'(seen_cyc[2] - seen_cyc[0]), 64'd2);
    end

    // reset with two ops in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = OP_OR; in_a = 32'hAB; in_b = '0; in_tag = 4'd5;
    @(negedge clk);
    in_tag = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    #1; chk("pre_rst_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_result", 64'(out_result), 64'd0);
    chk("midrst_flags", 64'(out_flags), 64'd0);
    chk("midrst_tag", 64'(out_tag), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk($sformatf("midrst_no_out_k%0d", k), 64'(out_valid), 64'd0);
    end

    // randomized runs on the 8- and 64-bit instances
    go_rand = 1'b1;
    wait (g_rnd[0].done_flag && g_rnd[1].done_flag);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
